act_skew_feeder: RTL and testbench

ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

---
 rtl/act_skew_feeder.sv | 195 +++++++++++++++++++
 tb/tb_act_skew_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: per-row FIFOs drive the array's west border,
// with row r released r cycles after the first accepted input vector.
module act_skew_feeder #(
  parameter int ACT_W = 8,
  parameter int ROWS  = 64,
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [15:0]           cfg_rows,
  input  logic [15:0]           cfg_k_steps,
  input  logic                  start,
  input  logic [ROWS*ACT_W-1:0] in_vec,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [ROWS*ACT_W-1:0] west_act_out,
  output logic [ROWS-1:0]       west_act_vld,
  input  logic [ROWS-1:0]       west_act_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [SW-1:0] SKEW_MAX = SW'(ROWS - 1);
  localparam logic [15:0] ROWS16 = 16'(ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_e;

  state_e state_q, state_d;
  logic [15:0] rows_q, rows_d;
  logic [15:0] k_q, k_d;
  logic [15:0] acc_q, acc_d;
  logic skew_on_q, skew_on_d;
  logic [SW-1:0] skew_q, skew_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q [ROWS];
  logic [PW-1:0] rd_ptr_d [ROWS];
  logic [15:0] emit_q [ROWS];
  logic [15:0] emit_d [ROWS];
  logic [ACT_W-1:0] mem_q [ROWS][DEPTH];
  logic [ACT_W-1:0] mem_d [ROWS][DEPTH];
  logic [31:0] stall_q, stall_d;

  logic [ROWS-1:0] active;
  logic [ROWS-1:0] full;
  logic [ROWS-1:0] pop;
  logic [ROWS-1:0] row_fin;
  logic blocked;
  logic all_fin;
  logic in_xfer;
  logic [15:0] eff_rows;

  assign eff_rows = (cfg_rows > ROWS16) ? ROWS16 : cfg_rows;
  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign stall_cycles = stall_q;

  // A row full only blocks input if it is not popping this same cycle.
  always_comb begin
    west_act_out = '0;
    west_act_vld = '0;
    active = '0;
    full = '0;
    pop = '0;
    row_fin = '0;
    blocked = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      active[r] = rows_q > 16'(r);
      full[r] = (wr_ptr_q[AW-1:0] == rd_ptr_q[r][AW-1:0])
             && (wr_ptr_q[AW] != rd_ptr_q[r][AW]);
      west_act_vld[r] = active[r] && skew_on_q
                     && (skew_q >= SW'(r))
                     && (wr_ptr_q != rd_ptr_q[r]);
      if (active[r]) begin
        west_act_out[r*ACT_W +: ACT_W] =
          mem_q[r][rd_ptr_q[r][AW-1:0]];
      end
      pop[r] = west_act_vld[r] && west_act_rdy[r] && clk_en;
      blocked = blocked | (active[r] && full[r] && !pop[r]);
      row_fin[r] = !active[r]
                || ((emit_q[r] + 16'(pop[r])) == k_q);
    end
    all_fin = &row_fin;
    in_rdy = (state_q == STREAM) && (acc_q < k_q) && !blocked;
    in_xfer = in_rdy && in_vld && clk_en;
  end

  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    k_d = k_q;
    acc_d = acc_q;
    skew_on_d = skew_on_q;
    skew_d = skew_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    emit_d = emit_q;
    mem_d = mem_q;
    stall_d = stall_q;

    if (in_xfer) begin
      acc_d = acc_q + 16'd1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      for (int r = 0; r < ROWS; r++) begin
        if (active[r]) begin
          mem_d[r][wr_ptr_q[AW-1:0]] = in_vec[r*ACT_W +: ACT_W];
        end
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      if (pop[r]) begin
        rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
        emit_d[r] = emit_q[r] + 16'd1;
      end
    end

    if ((state_q == STREAM) && in_vld && !in_rdy
        && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end

    if (!skew_on_q) begin
      if (in_xfer) skew_on_d = 1'b1;
    end else if (skew_q != SKEW_MAX) begin
      skew_d = skew_q + SW'(1);
    end

    unique case (state_q)
      IDLE: begin
        skew_on_d = 1'b0;
        skew_d = '0;
        wr_ptr_d = '0;
        acc_d = '0;
        for (int r = 0; r < ROWS; r++) begin
          rd_ptr_d[r] = '0;
          emit_d[r] = '0;
        end
        if (start) begin
          rows_d = eff_rows;
          k_d = cfg_k_steps;
          state_d = (eff_rows == 16'd0 || cfg_k_steps == 16'd0)
                  ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (acc_d == k_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_fin) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        rows_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      skew_on_q <= 1'b0;
      skew_q <= '0;
      wr_ptr_q <= '0;
      stall_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        rd_ptr_q[r] <= '0;
        emit_q[r] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[r][d] <= '0;
        end
      end
    end else if (clk_en) begin
      state_q <= state_d;
      rows_q <= rows_d;
      k_q <= k_d;
      acc_q <= acc_d;
      skew_on_q <= skew_on_d;
      skew_q <= skew_d;
      wr_ptr_q <= wr_ptr_d;
      stall_q <= stall_d;
      rd_ptr_q <= rd_ptr_d;
      emit_q <= emit_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: vector table for timing-exact jobs plus
// directed sequences for backpressure, reset and degenerate jobs.
module tb_act_skew_feeder;
  localparam int ACT_W = 8;
  localparam int ROWS  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic [15:0] cfg_rows;
  logic [15:0] cfg_k_steps;
  logic start;
  logic [ROWS*ACT_W-1:0] in_vec;
  logic in_vld;
  logic [ROWS-1:0] west_act_rdy;

  logic a_in_rdy, b_in_rdy;
  logic [ROWS*ACT_W-1:0] a_out, b_out;
  logic [ROWS-1:0] a_vld, b_vld;
  logic a_busy, b_busy, a_done, b_done;
  logic [31:0] a_stall, b_stall;

  logic sel;
  logic o_in_rdy, o_busy, o_done;
  logic [ROWS*ACT_W-1:0] o_out;
  logic [ROWS-1:0] o_vld;
  logic [31:0] o_stall;

  always #5 clk = ~clk;

  act_skew_feeder #(.ACT_W(ACT_W), .ROWS(ROWS), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cfg_rows(cfg_rows), .cfg_k_steps(cfg_k_steps), .start(start),
    .in_vec(in_vec), .in_vld(in_vld), .in_rdy(a_in_rdy),
    .west_act_out(a_out), .west_act_vld(a_vld),
    .west_act_rdy(west_act_rdy), .busy(a_busy), .done(a_done),
    .stall_cycles(a_stall)
  );

  act_skew_feeder #(.ACT_W(ACT_W), .ROWS(ROWS), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cfg_rows(cfg_rows), .cfg_k_steps(cfg_k_steps), .start(start),
    .in_vec(in_vec), .in_vld(in_vld), .in_rdy(b_in_rdy),
    .west_act_out(b_out), .west_act_vld(b_vld),
    .west_act_rdy(west_act_rdy), .busy(b_busy), .done(b_done),
    .stall_cycles(b_stall)
  );

  assign o_in_rdy = sel ? b_in_rdy : a_in_rdy;
  assign o_out    = sel ? b_out    : a_out;
  assign o_vld    = sel ? b_vld    : a_vld;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_done   = sel ? b_done   : a_done;
  assign o_stall  = sel ? b_stall  : a_stall;

  typedef struct {
    logic en;
    logic start;
    logic [15:0] k;
    logic vld;
    logic [3:0] rdy;
    logic e_rdy;
    logic [3:0] e_vld;
    logic e_busy;
    logic e_done;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int failures = 0;
  int src_idx = 0;
  int cur_k = 0;
  int cur_rows = 4;
  int emit[ROWS];
  int stall_model = 0;
  logic xfer;
  logic [ROWS-1:0] pops;

  function automatic logic [7:0] lane_val(int j, int r);
    return 8'((j + 1) * 16 + r);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(logic en, logic st, logic [15:0] k, logic v,
                     logic [3:0] rdy, logic er, logic [3:0] ev,
                     logic eb, logic ed);
    vec_t t;
    t.en = en; t.start = st; t.k = k; t.vld = v; t.rdy = rdy;
    t.e_rdy = er; t.e_vld = ev; t.e_busy = eb; t.e_done = ed;
    tbl.push_back(t);
  endtask

  task automatic drive_vec();
    for (int r = 0; r < ROWS; r++) in_vec[r*ACT_W +: ACT_W] = lane_val(src_idx, r);
  endtask

  task automatic job_start(int k);
    src_idx = 0;
    cur_k = k;
    for (int r = 0; r < ROWS; r++) emit[r] = 0;
    drive_vec();
  endtask

  // Called at the negedge: data scoreboard and transfer bookkeeping.
  task automatic observe();
    for (int r = 0; r < ROWS; r++) begin
      if (o_vld[r]) begin
        chk($sformatf("head_r%0d", r), 32'(o_out[r*ACT_W +: ACT_W]),
            32'(lane_val(emit[r], r)));
      end else if (r >= cur_rows) begin
        chk($sformatf("idle_lane_r%0d", r), 32'(o_out[r*ACT_W +: ACT_W]), 0);
      end
    end
    xfer = clk_en && in_vld && o_in_rdy;
    pops = clk_en ? (o_vld & west_act_rdy) : '0;
    for (int r = 0; r < ROWS; r++) begin
      if (pops[r]) chk($sformatf("emit_le_k_r%0d", r), 32'(emit[r] < cur_k), 1);
    end
    if (clk_en && o_busy && in_vld && !o_in_rdy && src_idx < cur_k) stall_model++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (xfer) src_idx++;
    for (int r = 0; r < ROWS; r++) if (pops[r]) emit[r]++;
    drive_vec();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_vld = 1'b0;
    west_act_rdy = '0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_model = 0;
    job_start(0);
  endtask

  task automatic run_job(input int k, input int rdy1_low, input int exp_done);
    int done_c;
    logic [ROWS-1:0] vld_or;
    done_c = -1;
    vld_or = '0;
    cfg_k_steps = 16'(k);
    job_start(k);
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      start = (c == 0);
      in_vld = 1'b1;
      west_act_rdy = '1;
      west_act_rdy[1] = (c >= rdy1_low);
      @(negedge clk);
      observe();
      vld_or |= o_vld;
      if (rdy1_low > 0 && c == rdy1_low - 1) begin
        chk("stall_in_rdy", 32'(o_in_rdy), 0);
        chk("row0_drained_vld", 32'(o_vld[0]), 0);
        chk("row0_emit", emit[0], 2);
      end
      if (rdy1_low > 0 && c == rdy1_low) chk("pop_frees_slot", 32'(o_in_rdy), 1);
      if (o_done) done_c = c;
      advance();
    end
    start = 1'b0;
    in_vld = 1'b0;
    chk("done_cycle", done_c, exp_done);
    chk("accepted", src_idx, k);
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("emit_total_r%0d", r), emit[r], (r < cur_rows) ? k : 0);
      if (r >= cur_rows) chk($sformatf("inactive_vld_r%0d", r), 32'(vld_or[r]), 0);
    end
    @(negedge clk);
    observe();
    chk("busy_after_done", 32'(o_busy), 0);
    chk("done_one_cycle", 32'(o_done), 0);
    advance();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    cfg_rows = 16'd4;
    cfg_k_steps = 16'd0;
    in_vec = '0;
    for (int r = 0; r < ROWS; r++) emit[r] = 0;
    do_reset();

    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst_in_rdy_%0d", s), 32'(o_in_rdy), 0);
      chk($sformatf("rst_vld_%0d", s), 32'(o_vld), 0);
      chk($sformatf("rst_out_%0d", s), o_out, 0);
      chk($sformatf("rst_busy_%0d", s), 32'(o_busy), 0);
      chk($sformatf("rst_done_%0d", s), 32'(o_done), 0);
      chk($sformatf("rst_stall_%0d", s), o_stall, 0);
    end
    sel = 1'b0;
    @(posedge clk);
    #1;

    // 4 rows, k=3, free-running
    add(1, 1, 3, 1, 4'hF, 0, 4'h0, 0, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h0, 1, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h1, 1, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h3, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h7, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'hE, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'hC, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h8, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h0, 1, 1);
    add(1, 0, 3, 1, 4'hF, 0, 4'h0, 0, 0);
    // k=0 job
    add(1, 1, 0, 0, 4'hF, 0, 4'h0, 0, 0);
    add(1, 0, 0, 0, 4'hF, 0, 4'h0, 1, 1);
    add(1, 0, 0, 0, 4'hF, 0, 4'h0, 0, 0);
    // k=3 with clk_en low for 3 cycles mid-stream
    add(1, 1, 3, 1, 4'hF, 0, 4'h0, 0, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h0, 1, 0);
    add(0, 0, 3, 1, 4'hF, 1, 4'h1, 1, 0);
    add(0, 0, 3, 1, 4'hF, 1, 4'h1, 1, 0);
    add(0, 0, 3, 1, 4'hF, 1, 4'h1, 1, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h1, 1, 0);
    add(1, 0, 3, 1, 4'hF, 1, 4'h3, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h7, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'hE, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'hC, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h8, 1, 0);
    add(1, 0, 3, 1, 4'hF, 0, 4'h0, 1, 1);
    add(1, 0, 3, 1, 4'hF, 0, 4'h0, 0, 0);

    cur_rows = 4;
    foreach (tbl[i]) begin
      clk_en = tbl[i].en;
      start = tbl[i].start;
      cfg_k_steps = tbl[i].k;
      in_vld = tbl[i].vld;
      west_act_rdy = tbl[i].rdy;
      if (tbl[i].start) job_start(int'(tbl[i].k));
      @(negedge clk);
      observe();
      chk($sformatf("in_rdy[%0d]", i), 32'(o_in_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vld[%0d]", i), 32'(o_vld), 32'(tbl[i].e_vld));
      chk($sformatf("busy[%0d]", i), 32'(o_busy), 32'(tbl[i].e_busy));
      chk($sformatf("done[%0d]", i), 32'(o_done), 32'(tbl[i].e_done));
      advance();
    end
    clk_en = 1'b1;
    start = 1'b0;
    in_vld = 1'b0;
    chk("stall_tbl", o_stall, stall_model);

    // 2 of 4 rows active, k=5
    do_reset();
    sel = 1'b0;
    cfg_rows = 16'd2;
    cur_rows = 2;
    run_job(5, 0, 8);
    chk("stall_rows2", o_stall, stall_model);

    // DEPTH=2, row 1 backpressured for 10 cycles, k=8
    do_reset();
    sel = 1'b1;
    cfg_rows = 16'd2;
    cur_rows = 2;
    run_job(8, 10, 18);
    chk("stall_cycles", o_stall, 7);
    chk("stall_model", o_stall, stall_model);
    sel = 1'b0;

    // reset in the middle of DRAIN with entries pending
    do_reset();
    sel = 1'b0;
    cfg_rows = 16'd4;
    cur_rows = 4;
    cfg_k_steps = 16'd3;
    job_start(3);
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      in_vld = 1'b1;
      west_act_rdy = '0;
      @(negedge clk);
      observe();
      if (c == 5) begin
        chk("drain_vld_full", 32'(o_vld), 32'hF);
        chk("drain_busy", 32'(o_busy), 1);
      end
      if (c < 5) advance();
    end
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    in_vld = 1'b0;
    #1;
    chk("arst_vld", 32'(o_vld), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    chk("arst_in_rdy", 32'(o_in_rdy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_model = 0;
    job_start(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      observe();
      chk($sformatf("no_done_after_rst_%0d", c), 32'(o_done), 0);
      chk($sformatf("idle_after_rst_%0d", c), 32'(o_busy), 0);
      advance();
    end
    run_job(3, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
